// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared encodings and state type for the forwarding/hazard unit
package fwd_pkg;

   // Operand source selects presented to the EX operand muxes
   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // Register 0 is hardwired to zero and is never a forwarding source
   localparam int ZERO_REG = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/fwd_operand_cmp.sv
// rtl/fwd_operand_cmp.sv - per-operand producer match and next forwarding select
module fwd_operand_cmp
   import fwd_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] src_i,
   input  logic          used_i,
   input  logic [AW-1:0] id_ex_rd_i,
   input  logic          id_ex_we_i,
   input  logic [AW-1:0] ex_mem_rd_i,
   input  logic          ex_mem_we_i,
   output logic          match_ex_o,
   output logic          match_mem_o,
   output logic [1:0]    sel_next_o
);

   // Nearest producer wins: ID/EX will sit in EX/MEM by the time this operand reaches EX
   always_comb begin
      match_ex_o  = id_ex_we_i && (id_ex_rd_i != AW'(ZERO_REG)) &&
                    (id_ex_rd_i == src_i) && used_i;
      match_mem_o = ex_mem_we_i && (ex_mem_rd_i != AW'(ZERO_REG)) &&
                    (ex_mem_rd_i == src_i) && used_i;
      sel_next_o  = FWD_REG;
      if (match_ex_o) begin
         sel_next_o = FWD_EXMEM;
      end else if (match_mem_o) begin
         sel_next_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// rtl/forwarding_hazard_unit.sv - ID-stage forwarding select register and load-use stall FSM
module forwarding_hazard_unit
   import fwd_pkg::*;
#(
   parameter int AW         = 5,
   parameter int N_SRC      = 2,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_SRC*AW-1:0]   id_src,
   input  logic [N_SRC-1:0]      id_src_used,
   input  logic [AW-1:0]         id_ex_rd,
   input  logic                  id_ex_EscreveReg,
   input  logic                  id_ex_LeMem,
   input  logic [AW-1:0]         ex_mem_rd,
   input  logic                  ex_mem_EscreveReg,
   input  logic                  flush,
   output logic [2*N_SRC-1:0]    fwd_sel,
   output logic                  stall,
   output logic                  bubble,
   output logic [CNT_W-1:0]      stall_count
);

   localparam int               REM_W    = 3;
   localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL - 1);

   fsm_state_e           state_q, state_d;
   logic [REM_W-1:0]     rem_q, rem_d;
   logic [2*N_SRC-1:0]   fwd_sel_q, fwd_sel_d;
   logic [2*N_SRC-1:0]   sel_next;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [N_SRC-1:0]     match_ex, match_mem;
   logic                 hazard;
   logic                 stall_w;

   for (genvar i = 0; i < N_SRC; i++) begin : g_cmp
      fwd_operand_cmp #(.AW(AW)) u_cmp (
         .src_i       (id_src[i*AW +: AW]),
         .used_i      (id_src_used[i]),
         .id_ex_rd_i  (id_ex_rd),
         .id_ex_we_i  (id_ex_EscreveReg),
         .ex_mem_rd_i (ex_mem_rd),
         .ex_mem_we_i (ex_mem_EscreveReg),
         .match_ex_o  (match_ex[i]),
         .match_mem_o (match_mem[i]),
         .sel_next_o  (sel_next[2*i +: 2])
      );
   end

   // Load in ID/EX feeding an operand that is read right now
   always_comb begin
      hazard  = id_ex_LeMem && (|match_ex);
      stall_w = reset && !flush && ((state_q == IDLE && hazard) || state_q == STALL);
   end

   // Stall sequencing: the detect cycle is the first bubble, STALL covers the rest
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (flush) begin
         state_d = IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hazard && LOAD_STALL > 1) begin
                  state_d = STALL;
                  rem_d   = REM_INIT;
               end
            end
            STALL: begin
               rem_d = rem_q - REM_W'(1);
               if (rem_d == '0) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               rem_d   = '0;
            end
         endcase
      end
   end

   // Bubbles need no forwarding; the counter saturates instead of wrapping
   always_comb begin
      fwd_sel_d = (flush || stall_w) ? '0 : sel_next;
      cnt_d     = cnt_q;
      if (stall_w && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, select and counter registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         fwd_sel_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         fwd_sel_q <= fwd_sel_d;
         cnt_q     <= cnt_d;
      end
   end

   assign fwd_sel     = fwd_sel_q;
   assign stall       = stall_w;
   assign bubble      = stall_w;
   assign stall_count = cnt_q;

endmodule
